// File: rtl/wb_cache_arbiter_pkg.sv
// Shared widths, FSM state encodings and watchdog default for the cache bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_cache_arbiter_pkg;

  localparam int WB_ADDR_W = 24;
  localparam int RW        = 16;

  // Default watchdog limit in cycles (8-bit counter)
  localparam logic [7:0] ARB_TIMEOUT_DEF = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_G0   = 2'b01,
    S_G1   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts stalled strobe cycles, pulses expired when the limit is hit.
// Latency: expired is combinational in the cycle the count reaches TIMEOUT.
// Backpressure: none; observes the bus only. Built only with WB_ARB_TIMEOUT_EN.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic active,
  input  logic done,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt;

  // cnt holds the number of stalled cycles already seen, so the TIMEOUT-th
  // stalled cycle is the one where cnt == TIMEOUT-1
  assign expired = active & (cnt == TIMEOUT - 8'd1);

  // Count stalled cycles; restart on a response, an owner change or expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 8'd0;
    end else if (clear || done || expired) begin
      cnt <= 8'd0;
    end else if (active) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/wb_cache_arbiter.sv
// Two-master round-robin Wishbone arbiter (dcache = m0, icache = m1), grant held for whole cyc.
// Latency: 1 cycle to grant from idle; granted path and ack/err are combinational (0 cycles).
// Backpressure: non-owner waits indefinitely; optional watchdog (WB_ARB_TIMEOUT_EN) errors stalled cycles.
module wb_cache_arbiter
  import wb_cache_arbiter_pkg::*;
#(
  parameter int         AW      = WB_ADDR_W,
  parameter int         DW      = RW,
  parameter logic [7:0] TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_o_dat,
  input  logic [1:0]    m0_sel,
  input  logic          m0_4_burst,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_o_dat,
  input  logic [1:0]    m1_sel,
  input  logic          m1_4_burst,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m_i_dat,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_o_dat,
  output logic [1:0]    s_sel,
  output logic          s_4_burst,
  input  logic [DW-1:0] s_i_dat,
  input  logic          s_ack,
  input  logic          s_err,
  output logic [1:0]    grant
);

  arb_state_t state;
  logic       last;
  logic       own0;
  logic       own1;
  logic       wd_expired;

  // Ownership FSM: round-robin on ties, grant held while owner's cyc is high,
  // direct hand-off to a waiting master with no idle cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_cyc && (!m1_cyc || last)) begin
            state <= S_G0;
            grant <= 2'b01;
          end else if (m1_cyc) begin
            state <= S_G1;
            grant <= 2'b10;
          end
        end
        S_G0: begin
          if (!m0_cyc) begin
            last <= 1'b0;
            if (m1_cyc) begin
              state <= S_G1;
              grant <= 2'b10;
            end else begin
              state <= S_IDLE;
              grant <= 2'b00;
            end
          end
        end
        S_G1: begin
          if (!m1_cyc) begin
            last <= 1'b1;
            if (m0_cyc) begin
              state <= S_G0;
              grant <= 2'b01;
            end else begin
              state <= S_IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Route the owner's request to the slave side; everything zero when idle
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_o_dat   = '0;
    s_sel     = 2'b00;
    s_4_burst = 1'b0;
    case (state)
      S_G0: begin
        s_cyc     = m0_cyc;
        s_stb     = m0_stb;
        s_we      = m0_we;
        s_adr     = m0_adr;
        s_o_dat   = m0_o_dat;
        s_sel     = m0_sel;
        s_4_burst = m0_4_burst;
      end
      S_G1: begin
        s_cyc     = m1_cyc;
        s_stb     = m1_stb;
        s_we      = m1_we;
        s_adr     = m1_adr;
        s_o_dat   = m1_o_dat;
        s_sel     = m1_sel;
        s_4_burst = m1_4_burst;
      end
      default: ;
    endcase
  end

  // Responses only reach the owner, and only while it is actively strobing
  assign own0    = (state == S_G0) & m0_cyc & m0_stb;
  assign own1    = (state == S_G1) & m1_cyc & m1_stb;
  assign m0_ack  = own0 & s_ack;
  assign m1_ack  = own1 & s_ack;
  assign m0_err  = own0 & (s_err | wd_expired);
  assign m1_err  = own1 & (s_err | wd_expired);
  assign m_i_dat = s_i_dat;

`ifdef WB_ARB_TIMEOUT_EN
  logic grant_chg;
  logic wd_active;
  logic wd_done;

  // Flag an ownership change at the coming edge so the stall count restarts
  always_comb begin
    grant_chg = 1'b0;
    case (state)
      S_IDLE:  grant_chg = m0_cyc | m1_cyc;
      S_G0:    grant_chg = ~m0_cyc;
      S_G1:    grant_chg = ~m1_cyc;
      default: grant_chg = 1'b1;
    endcase
  end

  assign wd_active = s_cyc & s_stb & ~s_ack & ~s_err;
  assign wd_done   = s_ack | s_err;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .active  (wd_active),
    .done    (wd_done),
    .clear   (grant_chg),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// Self-checking bench for wb_cache_arbiter: directed scenarios plus randomized masters/slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_cache_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          mcyc [2];
  logic          mstb [2];
  logic          mwe  [2];
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mdat [2];
  logic [1:0]    msel [2];
  logic          mbur [2];
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m_i_dat;
  logic          s_cyc, s_stb, s_we, s_4_burst;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_o_dat;
  logic [1:0]    s_sel;
  logic [DW-1:0] s_i_dat = '0;
  logic          s_ack = 1'b0;
  logic          s_err = 1'b0;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1) and who owned it last
  int owner  = 0;
  int last_m = 1;
  int wd_cnt = 0;

  always #5 i_clk = ~i_clk;

  wb_cache_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8'(TO))) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .m0_cyc     (mcyc[0]),
    .m0_stb     (mstb[0]),
    .m0_we      (mwe[0]),
    .m0_adr     (madr[0]),
    .m0_o_dat   (mdat[0]),
    .m0_sel     (msel[0]),
    .m0_4_burst (mbur[0]),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m1_cyc     (mcyc[1]),
    .m1_stb     (mstb[1]),
    .m1_we      (mwe[1]),
    .m1_adr     (madr[1]),
    .m1_o_dat   (mdat[1]),
    .m1_sel     (msel[1]),
    .m1_4_burst (mbur[1]),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m_i_dat    (m_i_dat),
    .s_cyc      (s_cyc),
    .s_stb      (s_stb),
    .s_we       (s_we),
    .s_adr      (s_adr),
    .s_o_dat    (s_o_dat),
    .s_sel      (s_sel),
    .s_4_burst  (s_4_burst),
    .s_i_dat    (s_i_dat),
    .s_ack      (s_ack),
    .s_err      (s_err),
    .grant      (grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit own_cyc();
    return (owner == 0) ? 1'b0 : mcyc[owner-1];
  endfunction

  function automatic bit own_stb();
    return (owner == 0) ? 1'b0 : mstb[owner-1];
  endfunction

  task automatic model_reset();
    owner  = 0;
    last_m = 1;
    wd_cnt = 0;
  endtask

  // Advance the model with the inputs present at this clock edge
  task automatic model_edge();
    int prev;
    bit stalled;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    prev    = owner;
    stalled = own_cyc() && own_stb() && !s_ack && !s_err;
    if (s_ack || s_err) wd_cnt = 0;
    else if (stalled) wd_cnt = (wd_cnt == TO - 1) ? 0 : wd_cnt + 1;
    if (owner == 0) begin
      if (mcyc[0] && mcyc[1]) owner = (last_m == 1) ? 1 : 2;
      else if (mcyc[0])       owner = 1;
      else if (mcyc[1])       owner = 2;
    end else if (!mcyc[owner-1]) begin
      last_m = owner - 1;
      owner  = mcyc[2-owner] ? (3 - owner) : 0;
    end
    if (owner != prev) wd_cnt = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0; madr[i] = '0;
      mdat[i] = '0;   msel[i] = 2'b00; mbur[i] = 1'b0;
    end
    s_ack = 1'b0;
    s_err = 1'b0;
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    model_reset();
    clear_inputs();
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  // Every cycle: compare all outputs with what the model says they must be
  always @(negedge i_clk) begin : cmp
    logic [1:0] eg;
    bit ec, es, stall, exp_to;
    int oi;
    oi     = owner - 1;
    eg     = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    ec     = own_cyc();
    es     = own_stb();
    stall  = ec && es && !s_ack && !s_err;
`ifdef WB_ARB_TIMEOUT_EN
    exp_to = stall && (wd_cnt == TO - 1);
`else
    exp_to = 1'b0;
`endif
    chk("grant", 32'(grant), 32'(eg));
    chk("s_cyc", 32'(s_cyc), 32'(ec));
    chk("s_stb", 32'(s_stb), 32'(es));
    chk("s_we",  32'(s_we),  (owner == 0) ? 32'd0 : 32'(mwe[oi]));
    chk("s_adr", 32'(s_adr), (owner == 0) ? 32'd0 : 32'(madr[oi]));
    chk("s_o_dat", 32'(s_o_dat), (owner == 0) ? 32'd0 : 32'(mdat[oi]));
    chk("s_sel", 32'(s_sel), (owner == 0) ? 32'd0 : 32'(msel[oi]));
    chk("s_4_burst", 32'(s_4_burst), (owner == 0) ? 32'd0 : 32'(mbur[oi]));
    chk("m0_ack", 32'(m0_ack), 32'((owner == 1) && ec && es && s_ack));
    chk("m1_ack", 32'(m1_ack), 32'((owner == 2) && ec && es && s_ack));
    chk("m0_err", 32'(m0_err), 32'((owner == 1) && ec && es && (s_err || exp_to)));
    chk("m1_err", 32'(m1_err), 32'((owner == 2) && ec && es && (s_err || exp_to)));
    chk("m_i_dat", 32'(m_i_dat), 32'(s_i_dat));
  end

  initial begin
    int acks, m1acks, rem[2], gap[2];
    clear_inputs();

    // Reset state
    reset_dut();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);

    // Single m0 read to 0x000804, slave acks in the second cycle
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 24'h000804; msel[0] = 2'b11;
    step();
    chk("a_s_cyc", 32'(s_cyc), 32'd1);
    chk("a_s_adr", 32'(s_adr), 32'h000804);
    chk("a_grant", 32'(grant), 32'h1);
    acks = 0; m1acks = 0;
    for (int k = 0; k < 4; k++) begin
      s_ack = (k == 1);
      #1;
      acks   += int'(m0_ack);
      m1acks += int'(m1_ack);
      step();
      if (k == 1) begin
        s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
      end
    end
    chk("a_m0_ack_pulses", 32'(acks), 32'd1);
    chk("a_m1_ack_pulses", 32'(m1acks), 32'd0);

    // Simultaneous requests after reset: m0 first, then m1 without idle gap
    reset_dut();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    step();
    chk("b_grant_first", 32'(grant), 32'h1);
    step();
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    step();
    chk("b_grant_handoff", 32'(grant), 32'h2);
    chk("b_s_cyc_handoff", 32'(s_cyc), 32'd1);
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    step();

    // m0 burst with m1 waiting; m1 only granted after m0 cyc falls
    reset_dut();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mbur[0] = 1'b1; madr[0] = 24'h000100;
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      #1;
      chk("c_burst_hint", 32'(s_4_burst), 32'd1);
      chk("c_grant_hold", 32'(grant), 32'h1);
      step();
    end
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0; mbur[0] = 1'b0;
    step();
    chk("c_grant_m1", 32'(grant), 32'h2);

    // m1 leaves, m0 does writeback + refill (8 acks) under one cyc
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    step();
    chk("d_grant_m0", 32'(grant), 32'h1);
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    acks = 0;
    for (int b = 0; b < 8; b++) begin
      mwe[0] = (b < 4);
      s_ack  = 1'b1;
      #1;
      acks += int'(m0_ack);
      chk("d_grant_hold", 32'(grant), 32'h1);
      step();
    end
    chk("d_ack_count", 32'(acks), 32'd8);
    clear_inputs();
    step();

    // Reset during beat 2 of an m1 burst
    reset_dut();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mbur[1] = 1'b1;
    step();
    s_ack = 1'b1;
    step();
    step();
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("e_s_cyc_async", 32'(s_cyc), 32'd0);
    chk("e_s_stb_async", 32'(s_stb), 32'd0);
    chk("e_grant_async", 32'(grant), 32'd0);
    clear_inputs();
    step();
    i_rst_n = 1'b1;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: stalled slave, error on every TO-th stalled cycle
    begin
      int first, nerr;
      reset_dut();
      mcyc[0] = 1'b1; mstb[0] = 1'b1;
      step();
      first = 0; nerr = 0;
      for (int k = 1; k <= 9; k++) begin
        if (m0_err) begin
          nerr++;
          if (first == 0) first = k;
        end
        step();
      end
      chk("f_first_err_cycle", 32'(first), 32'(TO));
      chk("f_err_pulses", 32'(nerr), 32'd2);
      clear_inputs();
      step();
    end
`endif

    // Randomized traffic from both masters against a random slave
    reset_dut();
    rem[0] = 0; rem[1] = 0; gap[0] = 0; gap[1] = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        madr[i] = 24'($urandom);
        mdat[i] = 16'($urandom);
        mwe[i]  = 1'($urandom);
        msel[i] = 2'($urandom);
        if (mcyc[i]) begin
          mstb[i] = (($urandom % 4) != 0);
          if (owner == i + 1) begin
            rem[i]--;
            if (rem[i] <= 0) begin
              mcyc[i] = 1'b0; mstb[i] = 1'b0;
              gap[i]  = int'($urandom_range(0, 3));
            end
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else begin
          mcyc[i] = 1'b1; mstb[i] = 1'b1;
          mbur[i] = 1'($urandom);
          rem[i]  = int'($urandom_range(1, 10));
        end
      end
      s_ack   = (($urandom % 3) == 0);
      s_err   = !s_ack && (($urandom % 20) == 0);
      s_i_dat = 16'($urandom);
      step();
    end

    clear_inputs();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
